// File: rtl/adsr_envelope.sv
// ADSR amplitude-envelope stage for a streaming oscillator path.
// Each accepted sample is multiplied by the current envelope gain. The same
// accept then advances the envelope state machine by exactly one step, so all
// envelope timing is counted in sample periods rather than clock cycles.
// A single output register provides a full-throughput valid/ready pipeline.

module adsr_envelope #(
  parameter int width_p     = 12,
  parameter int env_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   gate_i,
  input  logic [env_width_p-1:0] attack_rate_i,
  input  logic [env_width_p-1:0] decay_rate_i,
  input  logic [env_width_p-1:0] sustain_level_i,
  input  logic [env_width_p-1:0] release_rate_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [env_width_p-1:0] env_o,
  output logic [2:0]             state_o
);

  // Product width: signed sample times a zero-extended (non-negative) gain.
  localparam int prod_w_lp = width_p + env_width_p + 1;

  localparam logic [env_width_p-1:0] env_max_lp  = {env_width_p{1'b1}};
  localparam logic [env_width_p-1:0] env_zero_lp = {env_width_p{1'b0}};

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_attack  = 3'd1,
    st_decay   = 3'd2,
    st_sustain = 3'd3,
    st_release = 3'd4
  } state_e;

  // Gain plus increment, computed one bit wider and clamped at full scale.
  function automatic logic [env_width_p-1:0] add_clamp(
    input logic [env_width_p-1:0] a,
    input logic [env_width_p-1:0] b
  );
    logic [env_width_p:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[env_width_p]) begin
      return env_max_lp;
    end else begin
      return sum[env_width_p-1:0];
    end
  endfunction

  // Gain minus decrement, computed one bit wider and clamped at a floor.
  // The top bit of the wide difference is the borrow (a < b).
  function automatic logic [env_width_p-1:0] sub_floor(
    input logic [env_width_p-1:0] a,
    input logic [env_width_p-1:0] b,
    input logic [env_width_p-1:0] floor_val
  );
    logic [env_width_p:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[env_width_p] || (diff[env_width_p-1:0] <= floor_val)) begin
      return floor_val;
    end else begin
      return diff[env_width_p-1:0];
    end
  endfunction

  // Signed sample times unsigned gain, arithmetic-shifted right by the gain
  // width. Both operands are widened to the full product width so the low
  // bits of an unsigned multiply equal the two's complement product; taking
  // the slice above the gain bits is a floor shift toward minus infinity.
  function automatic logic [width_p-1:0] scale(
    input logic [width_p-1:0]     sample,
    input logic [env_width_p-1:0] gain
  );
    logic [prod_w_lp-1:0] a_ext;
    logic [prod_w_lp-1:0] b_ext;
    logic [prod_w_lp-1:0] prod;
    a_ext = {{(prod_w_lp - width_p){sample[width_p-1]}}, sample};
    b_ext = {{(prod_w_lp - env_width_p){1'b0}}, gain};
    prod  = a_ext * b_ext;
    return prod[env_width_p +: width_p];
  endfunction

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [env_width_p-1:0] env_r;
  logic [env_width_p-1:0] env_nxt_s;
  logic [width_p-1:0]     data_r;
  logic [width_p-1:0]     data_nxt_s;
  logic                   valid_r;
  logic                   valid_nxt_s;
  logic                   ready_s;
  logic                   accept_s;

  // Candidate gains for each ramp, evaluated from the pre-update gain.
  logic [env_width_p-1:0] atk_val_s;
  logic [env_width_p-1:0] dec_val_s;
  logic [env_width_p-1:0] rel_val_s;

  assign atk_val_s = add_clamp(env_r, attack_rate_i);
  assign dec_val_s = sub_floor(env_r, decay_rate_i, sustain_level_i);
  assign rel_val_s = sub_floor(env_r, release_rate_i, env_zero_lp);

  // State register: advances only when the next-state logic says so.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= st_idle;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-gain logic; everything holds unless a sample is accepted.
  always_comb begin
    state_nxt_s = state_r;
    env_nxt_s   = env_r;
    if (accept_s) begin
      case (state_r)
        st_idle: begin
          env_nxt_s = env_zero_lp;
          if (gate_i) begin
            state_nxt_s = st_attack;
          end else begin
            state_nxt_s = st_idle;
          end
        end
        st_attack: begin
          if (!gate_i) begin
            state_nxt_s = st_release;
          end else begin
            env_nxt_s = atk_val_s;
            if (atk_val_s == env_max_lp) begin
              state_nxt_s = st_decay;
            end else begin
              state_nxt_s = st_attack;
            end
          end
        end
        st_decay: begin
          if (!gate_i) begin
            state_nxt_s = st_release;
          end else begin
            env_nxt_s = dec_val_s;
            if (dec_val_s == sustain_level_i) begin
              state_nxt_s = st_sustain;
            end else begin
              state_nxt_s = st_decay;
            end
          end
        end
        st_sustain: begin
          if (!gate_i) begin
            state_nxt_s = st_release;
          end else begin
            env_nxt_s   = sustain_level_i;
            state_nxt_s = st_sustain;
          end
        end
        st_release: begin
          if (gate_i) begin
            // Retrigger ramps up from wherever the release had reached.
            env_nxt_s = atk_val_s;
            if (atk_val_s == env_max_lp) begin
              state_nxt_s = st_decay;
            end else begin
              state_nxt_s = st_attack;
            end
          end else begin
            env_nxt_s = rel_val_s;
            if (rel_val_s == env_zero_lp) begin
              state_nxt_s = st_idle;
            end else begin
              state_nxt_s = st_release;
            end
          end
        end
        default: begin
          state_nxt_s = st_idle;
          env_nxt_s   = env_zero_lp;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      env_nxt_s   = env_r;
    end
  end

  // Handshake and output-register next values: load on accept, drain on ready.
  always_comb begin
    ready_s     = ~valid_r | ready_i;
    accept_s    = valid_i & ready_s;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    if (accept_s) begin
      data_nxt_s  = scale(data_i, env_r);
      valid_nxt_s = 1'b1;
    end else if (ready_i) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Datapath registers: scaled sample, its valid flag and the envelope gain.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_r  <= {width_p{1'b0}};
      valid_r <= 1'b0;
      env_r   <= env_zero_lp;
    end else begin
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      env_r   <= env_nxt_s;
    end
  end

  assign ready_o = ready_s;
  assign data_o  = data_r;
  assign valid_o = valid_r;
  assign env_o   = env_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: a behavioural envelope model predicts
// gain, state and handshake each cycle; scaled samples go through a queue
// scoreboard and are compared when the output handshake completes.

module tb_adsr_envelope;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        gate_i;
  logic [7:0]  attack_rate_i;
  logic [7:0]  decay_rate_i;
  logic [7:0]  sustain_level_i;
  logic [7:0]  release_rate_i;
  logic [11:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  env_o;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_env   = 0;
  int m_state = 0;
  bit m_valid = 1'b0;
  int exp_q[$];

  adsr_envelope #(.width_p(12), .env_width_p(8)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .gate_i         (gate_i),
    .attack_rate_i  (attack_rate_i),
    .decay_rate_i   (decay_rate_i),
    .sustain_level_i(sustain_level_i),
    .release_rate_i (release_rate_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .env_o          (env_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // floor(d * e / 256)
  function automatic int exp_scale(input int d, input int e);
    int p;
    p = d * e;
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  // One envelope step on an accepted sample, from the behavioural description.
  task automatic model_accept(input bit g);
    int a, r, s, dr, nx;
    a  = int'(attack_rate_i);
    r  = int'(release_rate_i);
    s  = int'(sustain_level_i);
    dr = int'(decay_rate_i);
    if (m_state == 0) begin
      m_env = 0;
      if (g) m_state = 1;
    end else if (m_state == 1) begin
      if (!g) m_state = 4;
      else begin
        nx = m_env + a;
        if (nx >= 255) begin nx = 255; m_state = 2; end
        m_env = nx;
      end
    end else if (m_state == 2) begin
      if (!g) m_state = 4;
      else begin
        nx = m_env - dr;
        if (nx <= s) begin nx = s; m_state = 3; end
        m_env = nx;
      end
    end else if (m_state == 3) begin
      if (!g) m_state = 4;
      else m_env = s;
    end else begin
      if (g) begin
        nx = m_env + a;
        if (nx >= 255) begin nx = 255; m_state = 2; end
        else m_state = 1;
        m_env = nx;
      end else begin
        nx = m_env - r;
        if (nx <= 0) begin nx = 0; m_state = 0; end
        m_env = nx;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs, update model, advance one clock.
  task automatic step(input bit g, input bit v, input bit r, input int d);
    bit acc;
    bit m_ready;
    int exp_d;
    gate_i  = g;
    valid_i = v;
    ready_i = r;
    data_i  = d[11:0];
    #1;
    m_ready = !m_valid || r;
    chk("valid_o", int'(valid_o), int'(m_valid));
    chk("ready_o", int'(ready_o), int'(m_ready));
    chk("env_o",   int'(env_o),   m_env);
    chk("state_o", int'(state_o), m_state);
    if (m_valid && r) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        exp_d = exp_q.pop_front();
        chk("data_o", int'($signed(data_o)), exp_d);
      end
    end
    acc = v && m_ready;
    if (acc) begin
      exp_q.push_back(exp_scale(int'($signed(d[11:0])), m_env));
      model_accept(g);
      m_valid = 1'b1;
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    bit g;
    reset_ni = 1'b0;
    gate_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = 12'd0;
    attack_rate_i = 8'd64; decay_rate_i = 8'd100;
    sustain_level_i = 8'd100; release_rate_i = 8'd60;
    #12;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data",  int'(data_o), 0);
    chk("rst_env",   int'(env_o), 0);
    chk("rst_state", int'(state_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Attack ramp from idle; first sample at gain 0 with full-scale negative input.
    step(1, 1, 1, -2048);
    step(1, 1, 1, 1000);
    step(1, 1, 1, 1000);
    step(1, 1, 1, 1000);   // scaled by 128 -> 500
    step(1, 1, 1, 1000);
    chk("atk_top_env", int'(env_o), 255);
    chk("atk_top_state", int'(state_o), 2);
    step(1, 1, 1, -1000);  // scaled by 255 -> -997
    step(1, 1, 1, 1000);
    chk("sus_env", int'(env_o), 100);
    chk("sus_state", int'(state_o), 3);
    // Release, then retrigger at 40.
    step(0, 1, 1, 700);
    step(0, 1, 1, 700);
    chk("rel_env", int'(env_o), 40);
    step(1, 1, 1, 700);
    chk("retrig_env", int'(env_o), 104);
    chk("retrig_state", int'(state_o), 1);
    step(0, 1, 1, -300);
    step(0, 1, 1, -300);
    step(0, 1, 1, -300);
    chk("idle_state", int'(state_o), 0);

    // Backpressure: hold for 5 cycles, then resume.
    step(1, 1, 1, 1500);
    step(1, 1, 1, 1500);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 100 + i);
    chk("bp_ready", int'(ready_o), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 200 + 50 * i);

    // Randomised traffic with random rates, gate runs and flow control.
    g = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        attack_rate_i   = 8'($urandom_range(0, 90));
        decay_rate_i    = 8'($urandom_range(0, 90));
        sustain_level_i = 8'($urandom_range(0, 255));
        release_rate_i  = 8'($urandom_range(0, 90));
      end
      if ($urandom_range(0, 19) == 0) g = ~g;
      step(g, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4095)) - 2048);
    end

    // Drain.
    for (int i = 0; i < 3; i++) step(g, 0, 1, 0);
    chk("sb_drained", exp_q.size(), 0);

    // Reset mid-stream with a held output at gain 200.
    attack_rate_i = 8'd200;
    step(0, 1, 1, 0);
    for (int i = 0; i < 4 && m_state != 0; i++) step(0, 1, 1, 0);
    release_rate_i = 8'd255;
    step(0, 1, 1, 0);
    step(1, 1, 1, 1000);
    step(1, 1, 1, 1000);
    step(1, 1, 0, 1000);
    chk("pre_rst_env", int'(env_o), 200);
    chk("pre_rst_valid", int'(valid_o), 1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_data",  int'(data_o), 0);
    chk("mid_rst_env",   int'(env_o), 0);
    chk("mid_rst_state", int'(state_o), 0);
    m_env = 0; m_state = 0; m_valid = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    reset_ni = 1'b1;
    step(1, 1, 1, 800);
    step(1, 1, 1, 800);
    step(1, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Streaming amplitude-envelope stage directly downstream of the wavetable oscillators (sawtooth/sine/etc.).
- Consumes one signed oscillator sample per valid/ready handshake and multiplies it by an ADSR envelope gain. The gain is driven by a note gate.
- Emits the scaled sample toward the mixer/DAC with its own valid/ready handshake.
- The envelope advances exactly once per accepted sample, so timing is in sample periods, not clocks.

Parameters:
width_p, 12, sample width (signed two's complement, in and out)
env_width_p, 8, envelope gain width (unsigned); max gain env_max = 2^env_width_p - 1

Ports:
clk_i  input  1  clock
reset_ni  input  1  asynchronous active-low reset
gate_i  input  1  note gate (1 = key held)
attack_rate_i  input  env_width_p  gain increment per sample in ATTACK
decay_rate_i  input  env_width_p  gain decrement per sample in DECAY
sustain_level_i  input  env_width_p  SUSTAIN gain
release_rate_i  input  env_width_p  gain decrement per sample in RELEASE
data_i  input  width_p  signed oscillator sample
valid_i  input  1  data_i valid
ready_o  output  1  stage can accept data_i
data_o  output  width_p  signed scaled sample
valid_o  output  1  data_o valid
ready_i  input  1  downstream accepts data_o
env_o  output  env_width_p  current gain env_q (debug/metering)
state_o  output  3  encoded FSM state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4

Behaviour:
- Reset (async assert, sync deassert use): data_o=0, valid_o=0, env_q=0, state=IDLE. Asserting reset mid-stream discards the held output immediately.
- Handshake:
  - Input accept = valid_i & ready_o, where ready_o = ~valid_o | ready_i (single output register, full throughput).
  - On accept: data_o <= sat-free product (see below), valid_o <= 1.
  - Else if ready_i: valid_o <= 0.
  - While valid_o & ~ready_i: data_o, valid_o, env_q and state all hold.
- Latency: 1 clock from accept to data_o valid.
- Scaling: data_o = (signed data_i * unsigned env_q) >>> env_width_p.
  - Arithmetic shift, so the result floors toward minus infinity.
  - Low width_p bits are kept. No overflow is possible since env_q < 2^env_width_p.
  - The env_q used is the value before this sample's update.
- Envelope/FSM: updates only on an input accept. gate_i is sampled at that accept. Arithmetic is done at env_width_p+1 bits, then clamped.
  - IDLE: env=0. gate=1 -> ATTACK.
  - ATTACK: env=min(env+attack_rate, env_max). On reaching env_max -> DECAY. gate=0 -> RELEASE (takes priority, no increment that sample).
  - DECAY: env=max(env-decay_rate, sustain_level). On reaching sustain_level -> SUSTAIN. gate=0 -> RELEASE.
  - SUSTAIN: env=sustain_level_i, tracking live changes. gate=0 -> RELEASE.
  - RELEASE: env=max(env-release_rate, 0). On reaching 0 -> IDLE. gate=1 -> ATTACK (retrigger from the current env, no jump to 0).
- Boundary conditions:
  - Zero rate stalls the envelope in that state; this is legal.
  - sustain_level >= env_max: DECAY exits to SUSTAIN on its first sample.
  - Gate edges between accepts are ignored unless still present at the next accept.
- Rate/level inputs are sampled at each accept and need not be stable otherwise.

Test Plan:
- Reset mid-run: valid_o=1, env_q=200, drop reset_ni asynchronously -> data_o=0, valid_o=0, env_o=0, state_o=0 before the next edge.
- Attack ramp: gate=1, attack=64, data_i=1000 every cycle, ready_i=1 -> env_o 0,64,128,192,255, then state DECAY. data_o for the env=128 sample = 500.
- Negative scaling: env=255, data_i=-1000 -> data_o=-997. data_i=-2048, env=0 -> data_o=0.
- Decay/sustain/release: sustain=100, decay=100, release=60 from env=255 -> 155, 100 (SUSTAIN). Drop gate -> 40, 0, IDLE.
- Backpressure: ready_i=0 for 5 cycles with valid_i=1 -> ready_o=0, data_o/env_o/state_o constant. ready_i=1 -> accepts resume one per cycle, no sample lost or duplicated.
- Retrigger: gate high during RELEASE at env=40, attack=64 -> next accepted sample env=104, state ATTACK.
